// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq shared definitions: opcodes (shared with the ALU),
// FSM state codes, IR field positions and decode helpers.
package ctrl_seq_pkg;

   localparam int DW   = 8;
   localparam int NREG = 4;
   localparam int RAW  = 2;

   localparam int IR_OP_HI = 7;
   localparam int IR_OP_LO = 4;
   localparam int IR_RD_HI = 3;
   localparam int IR_RD_LO = 2;
   localparam int IR_RS_HI = 1;
   localparam int IR_RS_LO = 0;

   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 0;

   typedef logic [3:0] op_t;

   localparam op_t OP_NOP   = 4'b0000;
   localparam op_t OP_ADD   = 4'b0001;
   localparam op_t OP_SUB   = 4'b0010;
   localparam op_t OP_AND   = 4'b0011;
   localparam op_t OP_OR    = 4'b0100;
   localparam op_t OP_XOR   = 4'b0101;
   localparam op_t OP_OUT   = 4'b0110;
   localparam op_t OP_IN    = 4'b0111;
   localparam op_t OP_MOV   = 4'b1000;
   localparam op_t OP_STORE = 4'b1001;
   localparam op_t OP_LDI   = 4'b1010;
   localparam op_t OP_BZ    = 4'b1011;
   localparam op_t OP_BN    = 4'b1100;
   localparam op_t OP_JMP   = 4'b1101;
   localparam op_t OP_NOP2  = 4'b1110;
   localparam op_t OP_HALT  = 4'b1111;

   typedef logic [2:0] state_t;

   localparam state_t S_FETCH    = 3'd0;
   localparam state_t S_DECODE   = 3'd1;
   localparam state_t S_EXEC     = 3'd2;
   localparam state_t S_WB       = 3'd3;
   localparam state_t S_IMM      = 3'd4;
   localparam state_t S_IN_WAIT  = 3'd5;
   localparam state_t S_OUT_WAIT = 3'd6;
   localparam state_t S_HALT     = 3'd7;

   function automatic op_t ir_op(input logic [7:0] ir);
      return ir[IR_OP_HI:IR_OP_LO];
   endfunction

   function automatic logic [RAW-1:0] ir_rd(input logic [7:0] ir);
      return ir[IR_RD_HI:IR_RD_LO];
   endfunction

   function automatic logic [RAW-1:0] ir_rs(input logic [7:0] ir);
      return ir[IR_RS_HI:IR_RS_LO];
   endfunction

   function automatic logic sets_flags(input op_t op);
      return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
   endfunction

   function automatic logic is_alu(input op_t op);
      return sets_flags(op) || op == OP_MOV;
   endfunction

   function automatic logic is_imm(input op_t op);
      return op inside {OP_LDI, OP_BZ, OP_BN, OP_JMP};
   endfunction

   function automatic logic is_nop(input op_t op);
      return op == OP_NOP || op == OP_NOP2;
   endfunction

endpackage

// File: rtl/ctrl_regfile.sv
// 4x8 register file: two async read ports, one write port.
// Reads see the pre-write value on a same-cycle write.
module ctrl_regfile
   import ctrl_seq_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           we,
   input  logic [RAW-1:0] waddr,
   input  logic [DW-1:0]  wdata,
   input  logic [RAW-1:0] raddr_a,
   output logic [DW-1:0]  rdata_a,
   input  logic [RAW-1:0] raddr_b,
   output logic [DW-1:0]  rdata_b
);

   logic [DW-1:0] regs [NREG];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata_a = regs[raddr_a];
   assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer: fetch/decode of 8-bit instructions,
// drives an external ALU, I/O handshakes and a data-memory write port.
module ctrl_seq
   import ctrl_seq_pkg::*;
#(
   parameter int IMEM_AW = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [7:0]         imem_data,
   output logic [7:0]         alu_a,
   output logic [7:0]         alu_b,
   output logic [3:0]         alu_sel,
   input  logic [7:0]         alu_y,
   input  logic [1:0]         alu_flag,
   input  logic [7:0]         in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [7:0]         out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               dmem_we,
   output logic [7:0]         dmem_addr,
   output logic [7:0]         dmem_wdata,
   output logic               halted
);

   state_t             state;
   state_t             state_nx;
   logic [IMEM_AW-1:0] pc;
   logic [IMEM_AW-1:0] pc_inc;
   logic [IMEM_AW-1:0] imm_pc;
   logic [7:0]         ir;
   logic [1:0]         flags;

   op_t                op;
   op_t                d_op;
   logic               d_exec;
   logic               take;

   logic               rf_we;
   logic [DW-1:0]      rf_wd;

   assign op     = ir_op(ir);
   assign d_op   = ir_op(imem_data);
   assign pc_inc = pc + IMEM_AW'(1);
   assign imm_pc = IMEM_AW'(imem_data);

   assign d_exec = is_alu(d_op) || d_op == OP_OUT
                || d_op == OP_STORE;

   assign take = (op == OP_BZ && flags[FLAG_Z])
              || (op == OP_BN && flags[FLAG_N])
              || op == OP_JMP;

   always_comb begin
      state_nx = state;
      case (state)
         S_FETCH: state_nx = S_DECODE;
         S_DECODE: begin
            unique case (1'b1)
               d_exec:            state_nx = S_EXEC;
               d_op == OP_IN:     state_nx = S_IN_WAIT;
               is_imm(d_op):      state_nx = S_IMM;
               d_op == OP_HALT:   state_nx = S_HALT;
               default:           state_nx = S_FETCH;
            endcase
         end
         S_EXEC: begin
            unique case (1'b1)
               is_alu(op):        state_nx = S_WB;
               op == OP_OUT:      state_nx = S_OUT_WAIT;
               default:           state_nx = S_FETCH;
            endcase
         end
         S_WB:       state_nx = S_FETCH;
         S_IMM:      state_nx = S_EXEC;
         S_IN_WAIT:  if (in_valid) state_nx = S_FETCH;
         S_OUT_WAIT: if (out_ready) state_nx = S_FETCH;
         S_HALT:     state_nx = S_HALT;
         default:    state_nx = S_FETCH;
      endcase
   end

   // ALU stays selected through WB so the result is still valid
   // when it is written back.
   always_comb begin
      alu_sel = OP_NOP;
      if (state == S_WB && is_alu(op)) begin
         alu_sel = op;
      end else if (state == S_EXEC && !is_imm(op)) begin
         alu_sel = op;
      end
   end

   always_comb begin
      rf_we = 1'b0;
      rf_wd = alu_y;
      unique case (1'b1)
         state == S_WB && is_alu(op): rf_we = 1'b1;
         state == S_IN_WAIT && in_valid: begin
            rf_we = 1'b1;
            rf_wd = in_data;
         end
         state == S_EXEC && op == OP_LDI: begin
            rf_we = 1'b1;
            rf_wd = imem_data;
         end
         default: rf_we = 1'b0;
      endcase
   end

   ctrl_regfile u_rf (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (rf_we),
      .waddr   (ir_rd(ir)),
      .wdata   (rf_wd),
      .raddr_a (ir_rd(ir)),
      .rdata_a (alu_a),
      .raddr_b (ir_rs(ir)),
      .rdata_b (alu_b)
   );

   assign imem_addr  = pc;
   assign in_ready   = state == S_IN_WAIT;
   assign out_valid  = state == S_OUT_WAIT;
   assign halted     = state == S_HALT;
   assign dmem_we    = state == S_EXEC && op == OP_STORE;
   assign dmem_addr  = alu_b;
   assign dmem_wdata = alu_y;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_FETCH;
         pc       <= '0;
         ir       <= '0;
         flags    <= '0;
         out_data <= '0;
      end else begin
         state <= state_nx;
         if (state == S_DECODE) begin
            ir <= imem_data;
            pc <= pc_inc;
         end
         if (state == S_EXEC && is_imm(op)) begin
            pc <= take ? imm_pc : pc_inc;
         end
         if (state == S_EXEC && op == OP_OUT) begin
            out_data <= alu_y;
         end
         if (state == S_WB && sets_flags(op)) begin
            flags <= alu_flag;
         end
      end
   end

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed-program bench for ctrl_seq with a combinational ALU model,
// a synchronous instruction ROM and an output/store scoreboard.
module tb_ctrl_seq;
   import ctrl_seq_pkg::*;

   logic       clk;
   logic       rst_n;
   logic [7:0] imem_addr;
   logic [7:0] imem_data;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [3:0] alu_sel;
   logic [7:0] alu_y;
   logic [1:0] alu_flag;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       dmem_we;
   logic [7:0] dmem_addr;
   logic [7:0] dmem_wdata;
   logic       halted;

   logic [7:0]  imem [256];
   logic [7:0]  exp_out [$];
   logic [15:0] exp_st [$];
   int          nvec;
   int          nerr;

   ctrl_seq #(.IMEM_AW(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_sel    (alu_sel),
      .alu_y      (alu_y),
      .alu_flag   (alu_flag),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .halted     (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) imem_data <= imem[imem_addr];

   always_comb begin
      case (alu_sel)
         OP_ADD:  alu_y = alu_a + alu_b;
         OP_SUB:  alu_y = alu_a - alu_b;
         OP_AND:  alu_y = alu_a & alu_b;
         OP_OR:   alu_y = alu_a | alu_b;
         OP_XOR:  alu_y = alu_a ^ alu_b;
         OP_MOV:  alu_y = alu_b;
         default: alu_y = alu_a;
      endcase
      alu_flag = {alu_y == 8'h00, alu_y[7]};
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every completed output or store pops one entry.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_out.size() == 0) begin
            check("out_unexpected", 32'(out_data), 32'hffff_ffff);
         end else begin
            check("out_data", 32'(out_data), 32'(exp_out.pop_front()));
         end
      end
      if (rst_n && dmem_we) begin
         if (exp_st.size() == 0) begin
            check("store_unexpected", 32'({dmem_addr, dmem_wdata}),
                  32'hffff_ffff);
         end else begin
            check("store", 32'({dmem_addr, dmem_wdata}),
                  32'(exp_st.pop_front()));
         end
      end
   end

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) imem[i] = 8'hF0;
   endtask

   task automatic poke(input int a, input logic [7:0] d);
      imem[a] = d;
   endtask

   task automatic enter_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      clear_mem();
   endtask

   task automatic leave_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_out_valid(input string name);
      int n;
      for (n = 0; n < 60; n++) begin
         if (out_valid) break;
         @(posedge clk);
         #1;
      end
      check(name, 32'(out_valid), 32'd1);
   endtask

   task automatic finish_prog(input string name);
      int n;
      for (n = 0; n < 200; n++) begin
         @(posedge clk);
         #1;
         if (halted) break;
      end
      check({name, "_halted"}, 32'(halted), 32'd1);
      @(negedge clk);
      check({name, "_outq"}, 32'(exp_out.size()), 32'd0);
      check({name, "_stq"}, 32'(exp_st.size()), 32'd0);
      exp_out.delete();
      exp_st.delete();
   endtask

   initial begin
      int n;
      int hold_ok;
      nvec      = 0;
      nerr      = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b1;
      clear_mem();

      // LDI R1,5; LDI R2,3; ADD R1,R2; OUT R1; BZ/BN fall through; OUT R2
      poke(8'h00, 8'hA4); poke(8'h01, 8'h05);
      poke(8'h02, 8'hA8); poke(8'h03, 8'h03);
      poke(8'h04, 8'h16); poke(8'h05, 8'h64);
      poke(8'h06, 8'hB0); poke(8'h07, 8'h40);
      poke(8'h08, 8'hC0); poke(8'h09, 8'h40);
      poke(8'h0A, 8'h68);
      poke(8'h40, 8'h64);
      #12;
      check("rst_imem_addr", 32'(imem_addr), 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_in_ready", 32'(in_ready), 32'h0);
      check("rst_dmem_we", 32'(dmem_we), 32'h0);
      check("rst_alu_sel", 32'(alu_sel), 32'h0);
      check("rst_halted", 32'(halted), 32'h0);
      check("rst_out_data", 32'(out_data), 32'h0);
      exp_out.push_back(8'h08);
      exp_out.push_back(8'h03);
      leave_reset();
      for (n = 1; n <= 60; n++) begin
         @(posedge clk);
         #1;
         if (out_valid) break;
      end
      check("add_latency", 32'(n), 32'd15);
      finish_prog("add");

      // SUB gives zero -> BZ 0x20 taken
      enter_reset();
      poke(8'h00, 8'hA4); poke(8'h01, 8'h03);
      poke(8'h02, 8'hA8); poke(8'h03, 8'h03);
      poke(8'h04, 8'h26);
      poke(8'h05, 8'hB0); poke(8'h06, 8'h20);
      poke(8'h07, 8'h68);
      poke(8'h20, 8'h64);
      exp_out.push_back(8'h00);
      leave_reset();
      for (n = 0; n < 60; n++) begin
         @(posedge clk);
         #1;
         if (imem_addr == 8'h20 || imem_addr == 8'h07) break;
      end
      check("bz_taken_pc", 32'(imem_addr), 32'h20);
      finish_prog("bz");

      // SUB gives 0xFF, flags=01: BZ falls through, BN 0x30 taken
      enter_reset();
      poke(8'h00, 8'hA4); poke(8'h01, 8'h03);
      poke(8'h02, 8'hA8); poke(8'h03, 8'h04);
      poke(8'h04, 8'h26);
      poke(8'h05, 8'hB0); poke(8'h06, 8'h20);
      poke(8'h07, 8'hC0); poke(8'h08, 8'h30);
      poke(8'h09, 8'h68);
      poke(8'h20, 8'h68);
      poke(8'h30, 8'h64);
      exp_out.push_back(8'hFF);
      leave_reset();
      finish_prog("bn");

      // OUT with out_ready held low
      enter_reset();
      out_ready = 1'b0;
      poke(8'h00, 8'hA4); poke(8'h01, 8'hA5);
      poke(8'h02, 8'h64);
      exp_out.push_back(8'hA5);
      leave_reset();
      @(posedge clk);
      #1;
      wait_out_valid("out_wait_valid");
      hold_ok = 1;
      for (int i = 0; i < 5; i++) begin
         if (!(out_valid === 1'b1 && out_data === 8'hA5)) hold_ok = 0;
         @(posedge clk);
         #1;
      end
      check("out_hold", 32'(hold_ok), 32'd1);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("out_release", 32'(out_valid), 32'd0);
      finish_prog("out");

      // IN R3 accepted on third cycle, then OUT and STORE of R3
      enter_reset();
      poke(8'h00, 8'hA0); poke(8'h01, 8'h10);
      poke(8'h02, 8'h7C);
      poke(8'h03, 8'h6C);
      poke(8'h04, 8'h9C);
      exp_out.push_back(8'h7E);
      exp_st.push_back(16'h107E);
      leave_reset();
      for (n = 0; n < 60; n++) begin
         @(posedge clk);
         #1;
         if (in_ready) break;
      end
      check("in_ready_up", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      check("in_ready_c2", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = 8'h7E;
      @(posedge clk);
      #1;
      check("in_ready_drop", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      in_data  = 8'h00;
      finish_prog("in");

      // AND/OR/XOR/MOV, both NOP encodings, flags held across MOV
      enter_reset();
      poke(8'h00, 8'hA0); poke(8'h01, 8'h0F);
      poke(8'h02, 8'hA4); poke(8'h03, 8'h3C);
      poke(8'h04, 8'h31); poke(8'h05, 8'h60);
      poke(8'h06, 8'h44); poke(8'h07, 8'h64);
      poke(8'h08, 8'h55); poke(8'h09, 8'h88);
      poke(8'h0A, 8'h00); poke(8'h0B, 8'hE5);
      poke(8'h0C, 8'hB0); poke(8'h0D, 8'h30);
      poke(8'h0E, 8'h64);
      poke(8'h30, 8'h68);
      exp_out.push_back(8'h0C);
      exp_out.push_back(8'h3C);
      exp_out.push_back(8'h0C);
      leave_reset();
      finish_prog("logic");

      // JMP 0xFF: pc wraps after decoding 0xFF, then HALT holds
      enter_reset();
      poke(8'h00, 8'hB0); poke(8'h01, 8'h10);
      poke(8'h02, 8'hD0); poke(8'h03, 8'hFF);
      poke(8'hFF, 8'h15);
      poke(8'h10, 8'h64);
      exp_out.push_back(8'h00);
      leave_reset();
      for (n = 0; n < 60; n++) begin
         @(posedge clk);
         #1;
         if (imem_addr == 8'hFF) break;
      end
      check("jmp_pc", 32'(imem_addr), 32'hFF);
      for (n = 0; n < 10; n++) begin
         @(posedge clk);
         #1;
         if (imem_addr != 8'hFF) break;
      end
      check("pc_wrap", 32'(imem_addr), 32'h00);
      finish_prog("wrap");
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (halted) n++;
      end
      check("halt_persist", 32'(n), 32'd100);

      // Async reset during OUT_WAIT
      enter_reset();
      out_ready = 1'b0;
      poke(8'h00, 8'hA4); poke(8'h01, 8'hA5);
      poke(8'h02, 8'h64);
      leave_reset();
      @(posedge clk);
      #1;
      wait_out_valid("rst_mid_valid");
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_out_valid", 32'(out_valid), 32'd0);
      check("rst_mid_out_data", 32'(out_data), 32'h00);
      check("rst_mid_pc", 32'(imem_addr), 32'h00);
      check("rst_mid_halted", 32'(halted), 32'd0);
      exp_out.push_back(8'hA5);
      out_ready = 1'b1;
      leave_reset();
      #1;
      check("rst_refetch_pc", 32'(imem_addr), 32'h00);
      finish_prog("rst_mid");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/ctrl_seq.md
CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 Parameter IMEM_AW, default 8, instruction-memory address width; pc width equals IMEM_AW.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 imem_addr  output  IMEM_AW  instruction fetch address; synchronous memory, data valid one cycle later.
REQ-005 imem_data  input  8  instruction byte: [7:4] opcode, [3:2] rd, [1:0] rs.
REQ-006 alu_a, alu_b  output  8 each  ALU operands, alu_a=R[rd], alu_b=R[rs].
REQ-007 alu_sel  output  4  ALU opcode (0001 ADD … 1001 STORE, 0000 NOP).
REQ-008 alu_y  input  8  ALU result; alu_flag  input  2  {Z,N} from ALU.
REQ-009 in_data  input  8; in_valid  input  1; in_ready  output  1  input-port handshake.
REQ-010 out_data  output  8; out_valid  output  1; out_ready  input  1  output-port handshake.
REQ-011 dmem_we  output  1; dmem_addr  output  8; dmem_wdata  output  8  data-memory write port.
REQ-012 halted  output  1  high while in HALT.

Function
REQ-013 States SHALL be FETCH, DECODE, EXEC, WB, IMM, IN_WAIT, OUT_WAIT, HALT.
REQ-014 FETCH: imem_addr=pc; next DECODE.
REQ-015 DECODE: ir<=imem_data, pc<=pc+1 (wraps modulo 2^IMEM_AW); next per opcode.
REQ-016 Opcodes 0001-0101, 1000: DECODE->EXEC (alu_sel=opcode, operands driven)->WB (R[rd]<=alu_y)->FETCH; 4 cycles per instruction.
REQ-017 Flag register {Z,N} SHALL load alu_flag in WB only for opcodes 0001-0101; held otherwise.
REQ-018 0110 OUT: EXEC drives alu_sel=0110, captures out_data<=alu_y -> OUT_WAIT with out_valid=1; stays until out_ready=1, then FETCH; out_data stable while out_valid.
REQ-019 0111 IN: IN_WAIT with in_ready=1; on in_valid=1 same cycle R[rd]<=in_data, then FETCH.
REQ-020 1001 STORE: EXEC asserts dmem_we for exactly one cycle, dmem_addr=R[rs], dmem_wdata=alu_y; then FETCH.
REQ-021 1010 LDI, 1011 BZ, 1100 BN, 1101 JMP: DECODE->IMM (imem_addr=pc)->next cycle consume imem_data as immediate, pc<=pc+1.
REQ-022 LDI: R[rd]<=imm. BZ/BN: pc<=imm if Z/N set, else pc+1. JMP: pc<=imm unconditionally; immediate truncated to IMEM_AW.
REQ-023 0000 NOP: DECODE->FETCH, no register or flag change.
REQ-024 1111 HALT: enter HALT, halted=1, remain until reset; opcodes 1110 treated as NOP.
REQ-025 Register file: 4x8, R0 writable; write and read same register same cycle returns old value.
REQ-026 alu_sel=0000, dmem_we=0, in_ready=0, out_valid=0 in all states not listed above.

Reset
REQ-027 rst_n low SHALL immediately force state=FETCH, pc=0, ir=0, R0-R3=0, flags=00, out_data=0, all outputs at REQ-026 idle values, halted=0.
REQ-028 Reset mid-handshake (IN_WAIT/OUT_WAIT) SHALL drop in_ready/out_valid asynchronously with no register write.

Structure
REQ-029 Shared package SHALL hold opcode constants, state enum, and IR field positions; ALU opcodes shared with the ALU.
REQ-030 One sub-module, ctrl_regfile (4x8, 2 read ports, 1 write port, async reset), SHALL be instantiated.

Verification
REQ-031 Program LDI R1,5; LDI R2,3; ADD R1,R2 -> R1=8, flags=00, ADD completes 4 cycles after its fetch.
REQ-032 LDI R1,3; LDI R2,3; SUB R1,R2; BZ 0x20 -> pc=0x20 on next FETCH; with R2=4, flags=01 and pc falls through.
REQ-033 OUT R1 (R1=0xA5) with out_ready low 5 cycles -> out_valid held, out_data=0xA5 stable, released cycle after out_ready=1.
REQ-034 IN R3 with in_valid at cycle 3 of IN_WAIT, in_data=0x7E -> R3=0x7E, in_ready low next cycle.
REQ-035 JMP 0xFF then instruction at 0xFF -> pc wraps to 0x00 after decode; HALT -> halted=1 persists 100 cycles.
REQ-036 rst_n asserted during OUT_WAIT -> out_valid=0 without clock edge; after release, fetch from pc=0.
